// File: rtl/fir_bank_engine.sv
// fir_bank_engine
//   Sequential multi-bank FIR engine: one multiply-accumulate per clock over a
//   TAPS-deep sample ring, using one of N_BANKS run-time loadable coefficient
//   banks. A filt_select code >= N_BANKS bypasses the filter and returns the
//   input sample unchanged (the ring is not written in bypass).
//
//   Build option: define FIR_BANK_ROUND_EN to round half up in the final
//   scaling step. Without it the scaling step truncates toward minus infinity
//   (floor). Latency is the same in both builds.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              sample request, accepted only while busy is low
//   filt_select        bank select (>= N_BANKS: bypass), captured on accept
//   val                input sample (signed), captured on accept
//   coef_we            coefficient write strobe
//   coef_bank          bank to write (>= N_BANKS: rejected)
//   coef_idx           tap index to write (>= TAPS: rejected)
//   coef_wdata         coefficient value, signed Q(COEF_W-COEF_FRAC).COEF_FRAC
//   coef_drop          1-cycle pulse: a coef_we was rejected
//   busy               high whenever the FSM is not IDLE
//   result             last filtered sample, held between updates
//   done               1-cycle pulse, result updated in the same cycle
//   state_dbg          current FSM state encoding, for observation only
//
// Handshake: start is a request with no ready signal. It is taken on a rising
//   clock edge only when busy is low; a start seen while busy is dropped, not
//   queued. Each accepted start produces exactly one done pulse unless rstn
//   is asserted before it completes.
module fir_bank_engine #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 23,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 30,
  parameter int N_BANKS   = 3,
  parameter int SEL_W     = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [SEL_W-1:0]         filt_select,
  input  logic [DATA_W-1:0]        val,
  input  logic                     coef_we,
  input  logic [SEL_W-1:0]         coef_bank,
  input  logic [$clog2(TAPS)-1:0]  coef_idx,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_drop,
  output logic                     busy,
  output logic [DATA_W-1:0]        result,
  output logic                     done,
  output logic [2:0]               state_dbg
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PRD_W = DATA_W + COEF_W;

  localparam logic [SEL_W-1:0] N_BANKS_S = SEL_W'(N_BANKS);
  localparam logic [IDX_W-1:0] TAPS_M1   = IDX_W'(TAPS - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef FIR_BANK_ROUND_EN
  // Half an LSB of the output, added before the shift: round half up.
  localparam logic signed [ACC_W-1:0] RND_BIAS =
    {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
`else
  localparam logic signed [ACC_W-1:0] RND_BIAS = '0;
`endif

  // Unity gain at tap 0 is the reset contents of every bank.
  localparam logic signed [COEF_W-1:0] COEF_ONE =
    {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  ring [TAPS];
  logic signed [COEF_W-1:0]  coef [N_BANKS][TAPS];
  logic [IDX_W-1:0]          wr_ptr;
  logic [IDX_W-1:0]          rd_ptr;
  logic [IDX_W-1:0]          k_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [SEL_W-1:0]          sel_q;
  logic [DATA_W-1:0]         val_q;
  logic                      bypass_q;
  logic [DATA_W-1:0]         scaled_q;

  logic                      coef_ok;
  logic signed [PRD_W-1:0]   prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   biased;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         sat_val;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    coef_ok  = 1'b0;
    prod     = '0;
    prod_ext = '0;
    biased   = '0;
    shifted  = '0;
    sat_val  = '0;

    coef_ok = coef_we && (state == S_IDLE) &&
              (coef_bank < N_BANKS_S) && (coef_idx <= TAPS_M1);

    // rd_ptr walks backwards from the newest sample, so tap k sees x[n-k].
    prod     = ring[rd_ptr] * coef[sel_q][k_cnt];
    prod_ext = ACC_W'(prod);

    biased  = acc + RND_BIAS;
    shifted = biased >>> COEF_FRAC;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      k_cnt     <= '0;
      acc       <= '0;
      sel_q     <= '0;
      val_q     <= '0;
      bypass_q  <= 1'b0;
      scaled_q  <= '0;
      result    <= '0;
      done      <= 1'b0;
      coef_drop <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        ring[i] <= '0;
      end
      for (int b = 0; b < N_BANKS; b++) begin
        for (int i = 0; i < TAPS; i++) begin
          coef[b][i] <= (i == 0) ? COEF_ONE : '0;
        end
      end
    end else begin
      done      <= 1'b0;
      coef_drop <= coef_we && !coef_ok;

      // A write in the same IDLE cycle as an accepted start lands here,
      // before the MAC phase reads the bank, so the new sample sees it.
      if (coef_ok) begin
        coef[coef_bank][coef_idx] <= coef_wdata;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            sel_q <= filt_select;
            val_q <= val;
            if (filt_select >= N_BANKS_S) begin
              bypass_q <= 1'b1;
              state    <= S_DONE;
            end else begin
              bypass_q <= 1'b0;
              state    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          ring[wr_ptr] <= val_q;
          rd_ptr       <= wr_ptr;
          wr_ptr       <= (wr_ptr == TAPS_M1) ? '0 : wr_ptr + 1'b1;
          acc          <= '0;
          k_cnt        <= '0;
          state        <= S_MAC;
        end

        S_MAC: begin
          acc    <= acc + prod_ext;
          rd_ptr <= (rd_ptr == '0) ? TAPS_M1 : rd_ptr - 1'b1;
          k_cnt  <= k_cnt + 1'b1;
          if (k_cnt == TAPS_M1) begin
            state <= S_SCALE;
          end
        end

        S_SCALE: begin
          scaled_q <= sat_val;
          state    <= S_DONE;
        end

        S_DONE: begin
          result <= bypass_q ? val_q : scaled_q;
          done   <= 1'b1;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
